// File: rtl/frost32_decode_stage.sv
// frost32_decode_stage
//
// Registered instruction-decode stage of the Frost32 core. It sits between
// fetch and register-read/execute.
//
// Each raw instruction word arrives over a valid/ready handshake and is split
// into group, register indices, opcode, immediate and load/store type. The
// decoded fields are then presented one cycle later over a second valid/ready
// handshake.
//
// Malformed encodings are flagged but still passed downstream, fully decoded.
//
// Multiplies and group-3 load/stores hold in_ready low for a programmable
// number of cycles after they are accepted. A synchronous flush drops the
// output slot and any pending hold-off.
//
// Instruction layout, MSB first:
//   group[4] | ra | rb | group 1     : opcode[4] | imm[IMM_WIDTH]
//                      | groups 0/2/3: rc | fill | opcode[4]
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous pipeline flush
//   in_valid/in_ready   upstream handshake
//   in_instr, in_pc     raw instruction and its address
//   out_valid/out_ready downstream handshake
//   out_*               registered decoded fields, plus the PC
module frost32_decode_stage #(
  parameter int INSTR_WIDTH       = 32,
  parameter int REG_IDX_WIDTH     = 4,
  parameter int PC_WIDTH          = 32,
  parameter int MUL_STALL_CYCLES  = 2,
  parameter int LDST_STALL_CYCLES = 1,
  localparam int IMM_WIDTH        = INSTR_WIDTH - 8 - 2 * REG_IDX_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_WIDTH-1:0]   in_instr,
  input  logic [PC_WIDTH-1:0]      in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_group,
  output logic [REG_IDX_WIDTH-1:0] out_ra_index,
  output logic [REG_IDX_WIDTH-1:0] out_rb_index,
  output logic [REG_IDX_WIDTH-1:0] out_rc_index,
  output logic [3:0]               out_opcode,
  output logic [IMM_WIDTH-1:0]     out_imm_val,
  output logic [2:0]               out_ldst_type,
  output logic                     out_causes_stall,
  output logic                     out_is_bad,
  output logic [PC_WIDTH-1:0]      out_pc
);

  localparam logic [3:0] MUL_CNT  = MUL_STALL_CYCLES[3:0];
  localparam logic [3:0] LDST_CNT = LDST_STALL_CYCLES[3:0];

  // rc and the 4-bit opcode share the IMM_WIDTH+4 bits below rb; the rest is fill
  localparam int FILL_HI = IMM_WIDTH + 3 - REG_IDX_WIDTH;

  // Combinational decode of in_instr
  logic [3:0]               dec_group;
  logic [REG_IDX_WIDTH-1:0] dec_ra;
  logic [REG_IDX_WIDTH-1:0] dec_rb;
  logic [REG_IDX_WIDTH-1:0] dec_rc;
  logic [3:0]               dec_opcode;
  logic [IMM_WIDTH-1:0]     dec_imm;
  logic [2:0]               dec_ldst;
  logic                     dec_bad;
  logic [3:0]               dec_cnt;
  logic [FILL_HI-4:0]       dec_fill;

  // Registered state
  logic                     valid_q,  valid_d;
  logic [3:0]               busy_q,   busy_d;
  logic [3:0]               group_q,  group_d;
  logic [REG_IDX_WIDTH-1:0] ra_q,     ra_d;
  logic [REG_IDX_WIDTH-1:0] rb_q,     rb_d;
  logic [REG_IDX_WIDTH-1:0] rc_q,     rc_d;
  logic [3:0]               opcode_q, opcode_d;
  logic [IMM_WIDTH-1:0]     imm_q,    imm_d;
  logic [2:0]               ldst_q,   ldst_d;
  logic                     stall_q,  stall_d;
  logic                     bad_q,    bad_d;
  logic [PC_WIDTH-1:0]      pc_q,     pc_d;

  logic xfer;

  // Field extraction, malformed-encoding detection and stall classification
  always_comb begin
    dec_group  = in_instr[INSTR_WIDTH-1 -: 4];
    dec_ra     = in_instr[INSTR_WIDTH-5 -: REG_IDX_WIDTH];
    dec_rb     = in_instr[INSTR_WIDTH-5-REG_IDX_WIDTH -: REG_IDX_WIDTH];
    dec_fill   = in_instr[FILL_HI:4];
    dec_rc     = '0;
    dec_opcode = 4'd0;
    dec_imm    = '0;
    dec_ldst   = 3'd0;
    dec_bad    = 1'b0;
    dec_cnt    = 4'd0;

    // Group 1 carries an immediate. Every other group, including the
    // illegal ones, is decoded with the register layout.
    case (dec_group)
      4'd1: begin
        dec_opcode = in_instr[IMM_WIDTH+3 -: 4];
        dec_imm    = in_instr[IMM_WIDTH-1:0];
      end
      default: begin
        dec_rc     = in_instr[IMM_WIDTH+3 -: REG_IDX_WIDTH];
        dec_opcode = in_instr[3:0];
        dec_bad    = (dec_fill != '0);
      end
    endcase

    case (dec_group)
      4'd0:    if (dec_opcode >= 4'd12) dec_bad = 1'b1; else dec_bad = dec_bad;
      4'd1:    dec_bad = dec_bad;
      4'd2:    if (dec_opcode >= 4'd4)  dec_bad = 1'b1; else dec_bad = dec_bad;
      4'd3:    if (dec_opcode >= 4'd8)  dec_bad = 1'b1; else dec_bad = dec_bad;
      default: dec_bad = 1'b1;
    endcase

    // Malformed words never stall and never report a load/store type
    if (!dec_bad) begin
      case (dec_group)
        4'd0, 4'd1: begin
          if (dec_opcode == 4'd4) dec_cnt = MUL_CNT; else dec_cnt = 4'd0;
        end
        4'd3: begin
          dec_ldst = dec_opcode[2:0];
          dec_cnt  = LDST_CNT;
        end
        default: dec_cnt = 4'd0;
      endcase
    end else begin
      dec_cnt = 4'd0;
    end
  end

  assign in_ready = rst_n & ~flush & (busy_q == 4'd0) & (~valid_q | out_ready);

  // in_ready already excludes flush, so flush always beats a transfer
  assign xfer = in_valid & in_ready;

  // Next-state: flush > transfer > drain, with fields held when not loaded
  always_comb begin
    valid_d  = valid_q;
    busy_d   = busy_q;
    group_d  = group_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rc_d     = rc_q;
    opcode_d = opcode_q;
    imm_d    = imm_q;
    ldst_d   = ldst_q;
    stall_d  = stall_q;
    bad_d    = bad_q;
    pc_d     = pc_q;

    if (flush) begin
      valid_d = 1'b0;
      busy_d  = 4'd0;
    end else if (xfer) begin
      valid_d  = 1'b1;
      busy_d   = dec_cnt;
      group_d  = dec_group;
      ra_d     = dec_ra;
      rb_d     = dec_rb;
      rc_d     = dec_rc;
      opcode_d = dec_opcode;
      imm_d    = dec_imm;
      ldst_d   = dec_ldst;
      stall_d  = (dec_cnt != 4'd0);
      bad_d    = dec_bad;
      pc_d     = in_pc;
    end else begin
      if (out_ready) valid_d = 1'b0; else valid_d = valid_q;
      if (busy_q != 4'd0) busy_d = busy_q - 4'd1; else busy_d = busy_q;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      busy_q   <= 4'd0;
      group_q  <= 4'd0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      opcode_q <= 4'd0;
      imm_q    <= '0;
      ldst_q   <= 3'd0;
      stall_q  <= 1'b0;
      bad_q    <= 1'b0;
      pc_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      group_q  <= group_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rc_q     <= rc_d;
      opcode_q <= opcode_d;
      imm_q    <= imm_d;
      ldst_q   <= ldst_d;
      stall_q  <= stall_d;
      bad_q    <= bad_d;
      pc_q     <= pc_d;
    end
  end

  assign out_valid        = valid_q;
  assign out_group        = group_q;
  assign out_ra_index     = ra_q;
  assign out_rb_index     = rb_q;
  assign out_rc_index     = rc_q;
  assign out_opcode       = opcode_q;
  assign out_imm_val      = imm_q;
  assign out_ldst_type    = ldst_q;
  assign out_causes_stall = stall_q;
  assign out_is_bad       = bad_q;
  assign out_pc           = pc_q;

endmodule

// File: tb/tb_frost32_decode_stage.sv
module tb_frost32_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_group;
  logic [3:0]  out_ra_index;
  logic [3:0]  out_rb_index;
  logic [3:0]  out_rc_index;
  logic [3:0]  out_opcode;
  logic [15:0] out_imm_val;
  logic [2:0]  out_ldst_type;
  logic        out_causes_stall;
  logic        out_is_bad;
  logic [31:0] out_pc;

  int passed;
  int total;

  frost32_decode_stage #(
    .INSTR_WIDTH(32), .REG_IDX_WIDTH(4), .PC_WIDTH(32),
    .MUL_STALL_CYCLES(2), .LDST_STALL_CYCLES(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_group(out_group), .out_ra_index(out_ra_index), .out_rb_index(out_rb_index),
    .out_rc_index(out_rc_index), .out_opcode(out_opcode), .out_imm_val(out_imm_val),
    .out_ldst_type(out_ldst_type), .out_causes_stall(out_causes_stall),
    .out_is_bad(out_is_bad), .out_pc(out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Compare every registered output against a hand-computed expectation
  task automatic chk_out(input string tag, input logic v, input logic [3:0] grp,
                         input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc,
                         input logic [3:0] op, input logic [15:0] imm, input logic [2:0] ldst,
                         input logic st, input logic bad, input logic [31:0] pc);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".group"}, {28'd0, out_group}, {28'd0, grp});
    chk({tag, ".ra"}, {28'd0, out_ra_index}, {28'd0, ra});
    chk({tag, ".rb"}, {28'd0, out_rb_index}, {28'd0, rb});
    chk({tag, ".rc"}, {28'd0, out_rc_index}, {28'd0, rc});
    chk({tag, ".opcode"}, {28'd0, out_opcode}, {28'd0, op});
    chk({tag, ".imm"}, {16'd0, out_imm_val}, {16'd0, imm});
    chk({tag, ".ldst"}, {29'd0, out_ldst_type}, {29'd0, ldst});
    chk({tag, ".stall"}, {31'd0, out_causes_stall}, {31'd0, st});
    chk({tag, ".bad"}, {31'd0, out_is_bad}, {31'd0, bad});
    chk({tag, ".pc"}, out_pc, pc);
  endtask

  task automatic chk_rdy(input string tag, input logic exp);
    #1;
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, exp});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    #3;
    chk_out("reset", 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0, 3'd0, 1'b0, 1'b0, 32'h0);
    chk_rdy("reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Back-to-back add then addi
    drive(1'b1, 32'h0123_0000, 32'h100);
    chk_rdy("add_in", 1'b1);
    cyc();
    drive(1'b1, 32'h1120_1234, 32'h104);
    chk_out("add", 1'b1, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 16'h0, 3'd0, 1'b0, 1'b0, 32'h100);
    chk_rdy("addi_in", 1'b1);
    cyc();
    drive(1'b0, 32'h0, 32'h0);
    chk_out("addi", 1'b1, 4'd1, 4'd1, 4'd2, 4'd0, 4'd0, 16'h1234, 3'd0, 1'b0, 1'b0, 32'h104);
    cyc();
    chk("drain.valid", {31'd0, out_valid}, 32'd0);

    // mul: two cycles of hold-off
    drive(1'b1, 32'h0123_0004, 32'h108);
    chk_rdy("mul_in", 1'b1);
    cyc();
    drive(1'b1, 32'h0123_0000, 32'h10C);
    chk_out("mul", 1'b1, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 16'h0, 3'd0, 1'b1, 1'b0, 32'h108);
    chk_rdy("mul_hold1", 1'b0);
    cyc();
    chk("mul_hold2.valid", {31'd0, out_valid}, 32'd0);
    chk_rdy("mul_hold2", 1'b0);
    cyc();
    chk_rdy("mul_release", 1'b1);
    cyc();
    drive(1'b1, 32'h3123_0006, 32'h110);
    chk_out("add2", 1'b1, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 16'h0, 3'd0, 1'b0, 1'b0, 32'h10C);
    chk_rdy("sth_in", 1'b1);

    // sth: one cycle of hold-off; opcode 8 in group 3 is malformed
    cyc();
    drive(1'b1, 32'h3123_0008, 32'h114);
    chk_out("sth", 1'b1, 4'd3, 4'd1, 4'd2, 4'd3, 4'd6, 16'h0, 3'd6, 1'b1, 1'b0, 32'h110);
    chk_rdy("sth_hold", 1'b0);
    cyc();
    chk_rdy("sth_release", 1'b1);
    cyc();
    drive(1'b1, 32'h0123_0010, 32'h118);
    chk_out("g3op8", 1'b1, 4'd3, 4'd1, 4'd2, 4'd3, 4'd8, 16'h0, 3'd0, 1'b0, 1'b1, 32'h114);
    chk_rdy("g3op8_nohold", 1'b1);
    cyc();
    drive(1'b1, 32'h5000_0000, 32'h11C);
    chk_out("fill", 1'b1, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 16'h0, 3'd0, 1'b0, 1'b1, 32'h118);
    chk_rdy("fill_nohold", 1'b1);
    cyc();
    drive(1'b0, 32'h0, 32'h0);
    chk_out("grp5", 1'b1, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0, 3'd0, 1'b0, 1'b1, 32'h11C);

    // Backpressure: out_ready low for three cycles
    cyc();
    drive(1'b1, 32'h2456_0003, 32'h120);
    chk_rdy("g2_in", 1'b1);
    cyc();
    out_ready = 1'b0;
    drive(1'b1, 32'h0789_0002, 32'h124);
    for (int i = 0; i < 3; i++) begin
      chk_out("bp_hold", 1'b1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd3, 16'h0, 3'd0, 1'b0, 1'b0, 32'h120);
      chk_rdy("bp_hold", 1'b0);
      cyc();
    end
    out_ready = 1'b1;
    chk_rdy("bp_release", 1'b1);
    chk_out("bp_release", 1'b1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd3, 16'h0, 3'd0, 1'b0, 1'b0, 32'h120);
    cyc();
    drive(1'b1, 32'h0123_0004, 32'h128);
    chk_out("bp_next", 1'b1, 4'd0, 4'd7, 4'd8, 4'd9, 4'd2, 16'h0, 3'd0, 1'b0, 1'b0, 32'h124);

    // Flush during the mul hold-off clears both the slot and the counter
    chk_rdy("mul2_in", 1'b1);
    cyc();
    drive(1'b1, 32'h0123_0000, 32'h12C);
    flush = 1'b1;
    chk_rdy("flush_busy", 1'b0);
    cyc();
    flush = 1'b0;
    chk("flush1.valid", {31'd0, out_valid}, 32'd0);
    chk_rdy("flush1_after", 1'b1);
    cyc();
    chk_out("post_flush1", 1'b1, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 16'h0, 3'd0, 1'b0, 1'b0, 32'h12C);

    // Flush with idle counter: nothing is accepted that cycle
    drive(1'b1, 32'h1120_1234, 32'h130);
    flush = 1'b1;
    chk_rdy("flush_idle", 1'b0);
    cyc();
    flush = 1'b0;
    chk("flush2.valid", {31'd0, out_valid}, 32'd0);
    chk("flush2.pc", out_pc, 32'h12C);
    chk_rdy("flush2_after", 1'b1);
    cyc();
    chk_out("post_flush2", 1'b1, 4'd1, 4'd1, 4'd2, 4'd0, 4'd0, 16'h1234, 3'd0, 1'b0, 1'b0, 32'h130);

    // Asynchronous reset in the middle of a mul hold-off
    drive(1'b1, 32'h0123_0004, 32'h134);
    cyc();
    drive(1'b1, 32'h0123_0000, 32'h138);
    chk("rst_pre.valid", {31'd0, out_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0, 3'd0, 1'b0, 1'b0, 32'h0);
    chk_rdy("async_rst", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_rdy("rst_release", 1'b1);
    cyc();
    chk_out("post_rst", 1'b1, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 16'h0, 3'd0, 1'b0, 1'b0, 32'h138);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/frost32_decode_stage.md
# frost32_decode_stage

Registered, parametrised instruction-decode pipeline stage for the Frost32 core. It accepts raw instruction words through a valid/ready handshake and splits them into group, register indices, opcode, immediate and load/store type. It flags malformed encodings and holds off fetch for a programmable number of cycles after multiply and load/store instructions. A synchronous flush input discards in-flight work on taken branches, jumps and calls. It sits between the fetch stage and the register-read/execute stage.

## Interface
- INSTR_WIDTH, 32, instruction word width
- REG_IDX_WIDTH, 4, width of ra/rb/rc index fields
- PC_WIDTH, 32, width of the PC carried alongside the instruction
- MUL_STALL_CYCLES, 2, extra cycles of in_ready hold-off after a multiply (0..15)
- LDST_STALL_CYCLES, 1, extra cycles of hold-off after a group-3 load/store (0..15)
- Derived: IMM_WIDTH = INSTR_WIDTH − 8 − 2·REG_IDX_WIDTH; must be ≥ 4 + REG_IDX_WIDTH
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  in_instr/in_pc are valid
- in_ready  out  1  stage accepts this cycle
- in_instr  in  INSTR_WIDTH  raw instruction
- in_pc  in  PC_WIDTH  address of in_instr
- out_valid  out  1  decoded output valid
- out_ready  in  1  downstream accepts output
- out_group  out  4  instruction group
- out_ra_index, out_rb_index, out_rc_index  out  REG_IDX_WIDTH each  register indices (rc = 0 for group 1)
- out_opcode  out  4  opcode within group
- out_imm_val  out  IMM_WIDTH  immediate (group 1 only, else 0)
- out_ldst_type  out  3  Ld32, LdU16, LdS16, LdU8, LdS8, St32, St16, St8 = 0..7 (group 3 only, else 0)
- out_causes_stall  out  1  decoded instruction triggers hold-off
- out_is_bad  out  1  malformed encoding
- out_pc  out  PC_WIDTH  registered in_pc

## Operation
- Field layout, MSB first: group[4], ra, rb. Then:
  - Group 1: opcode[4], imm[IMM_WIDTH].
  - Groups 0/2/3: rc, fill, opcode[4] in the low 4 bits.
- out_is_bad is set by any of:
  - group ≥ 4
  - group 0 with opcode 12..15
  - group 2 with opcode 4..15
  - group 3 with opcode 8..15
  - non-zero fill in groups 0/2/3
- Bad instructions still pass downstream with all fields decoded. out_causes_stall = 0 and out_ldst_type = 0 for bad instructions.
- Stall class:
  - Multiply is group 0 opcode 4 or group 1 opcode 4; loads MUL_STALL_CYCLES.
  - Group-3 opcodes 0..7 load LDST_STALL_CYCLES.
  - out_causes_stall = 1 iff the loaded count is non-zero.
- Accept: in_ready = rst_n & !flush & (busy_cnt == 0) & (!out_valid | out_ready). Transfer = in_valid & in_ready.
- On transfer: register all decoded fields, set out_valid, load busy_cnt with the stall count (0 if none).
- Else if out_ready: clear out_valid. Fields hold their last values.
- busy_cnt decrements by 1 each cycle while non-zero and no transfer occurs.
- flush: clears out_valid and busy_cnt in that cycle. in_ready = 0 that cycle. Flush beats a simultaneous transfer.
- While out_valid & !out_ready, all out_* stay stable.

## Timing
- Latency: 1 cycle, from transfer to out_valid.
- Throughput: 1 instruction/cycle for non-stalling instructions with out_ready held high.
- After a transfer with count N, in_ready is low for exactly N cycles, then rises. This holds even if out_ready is high.
- Reset (asynchronous assert; release synchronous to clk): out_valid = 0, every out_* field = 0, busy_cnt = 0. in_ready = 0 while rst_n is low.
- Reset mid-stall: busy_cnt is cleared. The first cycle after release has in_ready = 1.
- busy_cnt is 4 bits; values outside 0..15 are illegal parameters.

## Test plan
- Back-to-back 0x0123_0000 (add r1,r2,r3) then 0x1120_1234 (addi) with out_ready = 1 -> outputs on consecutive cycles. Second output: group=1, ra=1, rb=2, rc=0, opcode=0, imm=0x1234, is_bad=0.
- 0x0123_0004 (mul) with MUL_STALL_CYCLES = 2 -> causes_stall = 1. in_ready low for exactly 2 cycles after acceptance, then high.
- 0x3123_0006 (sth) -> ldst_type = 6 (St16), causes_stall = 1, 1-cycle hold-off. 0x3123_0008 -> is_bad = 1, no hold-off.
- 0x0123_0010 (non-zero fill) and 0x5000_0000 (group 5) -> is_bad = 1 on both, causes_stall = 0.
- out_ready low for 3 cycles while out_valid -> outputs stable and in_ready low. Release -> next instruction accepted in the same cycle.
- Flush asserted with in_valid high during a mul hold-off -> out_valid = 0 next cycle, busy_cnt = 0, nothing accepted that cycle, acceptance resumes the cycle after. Async rst_n pulse mid-stream -> all outputs 0 immediately.
